// File: rtl/key_repeat_pulser_pkg.sv
// Shared tetris input definitions: key FSM state encodings and the default
// delayed-auto-shift timing used by the left/right/down/rotate instances.
package key_repeat_pulser_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2,
    HOLD   = 2'd3
  } kr_state_e;

  localparam int unsigned DEFAULT_CNT_W        = 8;
  localparam int unsigned DEFAULT_DELAY_TICKS  = 16;
  localparam int unsigned DEFAULT_REPEAT_TICKS = 4;

endpackage : key_repeat_pulser_pkg

// File: rtl/key_repeat_pulser.sv
// Key repeat pulser: turns a debounced key level into one-cycle action
// strobes -- one on press, then delayed auto-shift repeats until release.
module key_repeat_pulser
  import key_repeat_pulser_pkg::*;
#(
  parameter int unsigned CNT_W        = DEFAULT_CNT_W,
  parameter int unsigned DELAY_TICKS  = DEFAULT_DELAY_TICKS,
  parameter int unsigned REPEAT_TICKS = DEFAULT_REPEAT_TICKS
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick_en,
  input  logic enable,
  input  logic key_lvl,
  output logic key_pulse,
  output logic key_held,
  output logic repeating
);

  // Terminal counts; REPEAT_LAST is unused when REPEAT_TICKS==0 (HOLD path).
  localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(DELAY_TICKS - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_TICKS - 1);
  localparam logic             NO_REPEAT   = (REPEAT_TICKS == 0);

  kr_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             key_q, key_d;
  logic             key_pulse_q, key_pulse_d;
  logic             key_held_q, key_held_d;
  logic             repeating_q, repeating_d;
  logic             press;

  assign key_d = key_lvl;
  assign press = key_lvl & ~key_q;

  // Next-state, counter and strobe decode; enable, then release, take priority.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    key_pulse_d = 1'b0;
    if (!enable) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (press) begin
            key_pulse_d = 1'b1;
            cnt_d       = '0;
            state_d     = NO_REPEAT ? HOLD : DELAY;
          end
        end
        DELAY: begin
          if (!key_lvl) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (tick_en) begin
            if (cnt_q == DELAY_LAST) begin
              key_pulse_d = 1'b1;
              cnt_d       = '0;
              state_d     = REPEAT;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        REPEAT: begin
          if (!key_lvl) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (tick_en && !key_pulse_q) begin
            // A tick landing on a strobe cycle is dropped, not counted, so
            // strobes can never sit on adjacent cycles.
            if (cnt_q == REPEAT_LAST) begin
              key_pulse_d = 1'b1;
              cnt_d       = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        HOLD: begin
          if (!key_lvl) begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Status outputs are registered copies decoded from the next state.
  always_comb begin
    key_held_d  = (state_d != IDLE);
    repeating_d = (state_d == REPEAT);
  end

  // State, counter, key history and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      key_q       <= 1'b0;
      key_pulse_q <= 1'b0;
      key_held_q  <= 1'b0;
      repeating_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      key_q       <= key_d;
      key_pulse_q <= key_pulse_d;
      key_held_q  <= key_held_d;
      repeating_q <= repeating_d;
    end
  end

  assign key_pulse = key_pulse_q;
  assign key_held  = key_held_q;
  assign repeating = repeating_q;

endmodule : key_repeat_pulser

// File: tb/tb_key_repeat_pulser.sv
// Directed bench for key_repeat_pulser: three instances (DAS repeat=2,
// repeat disabled, repeat=1) share one stimulus stream; each phase checks
// the instance it targets against hand-computed cycle numbers.
module tb_key_repeat_pulser;

  logic clk = 1'b0;
  logic rst_n, tick_en, enable, key_lvl;
  logic m_pulse, m_held, m_rep;   // DELAY=3 REPEAT=2
  logic h_pulse, h_held, h_rep;   // DELAY=3 REPEAT=0
  logic f_pulse, f_held, f_rep;   // DELAY=3 REPEAT=1

  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned cyc    = 0;
  logic        tick_all = 1'b0;

  logic pm [0:511];
  logic hm [0:511];
  logic rm [0:511];
  logic ph [0:511];
  logic hh [0:511];
  logic rh [0:511];
  logic pf [0:511];

  always #5 clk = ~clk;

  key_repeat_pulser #(.CNT_W(8), .DELAY_TICKS(3), .REPEAT_TICKS(2)) u_main (
    .clk(clk), .rst_n(rst_n), .tick_en(tick_en), .enable(enable), .key_lvl(key_lvl),
    .key_pulse(m_pulse), .key_held(m_held), .repeating(m_rep));

  key_repeat_pulser #(.CNT_W(8), .DELAY_TICKS(3), .REPEAT_TICKS(0)) u_hold (
    .clk(clk), .rst_n(rst_n), .tick_en(tick_en), .enable(enable), .key_lvl(key_lvl),
    .key_pulse(h_pulse), .key_held(h_held), .repeating(h_rep));

  key_repeat_pulser #(.CNT_W(8), .DELAY_TICKS(3), .REPEAT_TICKS(1)) u_fast (
    .clk(clk), .rst_n(rst_n), .tick_en(tick_en), .enable(enable), .key_lvl(key_lvl),
    .key_pulse(f_pulse), .key_held(f_held), .repeating(f_rep));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: sample #1 after the edge, then set up tick_en for the next edge.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    pm[cyc] = m_pulse; hm[cyc] = m_held; rm[cyc] = m_rep;
    ph[cyc] = h_pulse; hh[cyc] = h_held; rh[cyc] = h_rep;
    pf[cyc] = f_pulse;
    tick_en = tick_all | (cyc % 4 == 0);
  endtask

  task automatic step_to(input int unsigned c);
    while (cyc < c) step();
  endtask

  function automatic int unsigned cnt_pulses(input int unsigned which,
                                             input int unsigned lo, input int unsigned hi);
    int unsigned n = 0;
    for (int unsigned i = lo; i <= hi; i++) begin
      if (which == 0 && pm[i] === 1'b1) n++;
      if (which == 1 && ph[i] === 1'b1) n++;
      if (which == 2 && pf[i] === 1'b1) n++;
    end
    return n;
  endfunction

  initial begin
    int unsigned n;
    logic exp_p;
    rst_n = 1'b0; tick_en = 1'b0; enable = 1'b1; key_lvl = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_pulse", {29'd0, m_pulse, h_pulse, f_pulse}, 0);
    chk("reset_held",  {29'd0, m_held,  h_held,  f_held},  0);
    chk("reset_rep",   {29'd0, m_rep,   h_rep,   f_rep},   0);
    @(negedge clk);
    rst_n   = 1'b1;
    cyc     = 0;
    tick_en = 1'b1;  // ticks are sampled at edges 1,5,9,...

    // Press at cycle 10, held 40 cycles: pulses 11, then ticks 13,17,21 -> 21,
    // then every 2nd tick -> 29,37,45; release sampled at edge 51.
    step_to(10);
    key_lvl = 1'b1;
    step_to(50);
    key_lvl = 1'b0;
    step_to(51);
    chk("press_pulse_11", pm[11], 1);
    chk("press_pulse_12", pm[12], 0);
    chk("press_held_11",  hm[11], 1);
    chk("press_rep_11",   rm[11], 0);
    chk("delay_rep_20",   rm[20], 0);
    chk("first_rep_21",   rm[21], 1);
    for (int unsigned c = 11; c <= 50; c++) begin
      exp_p = (c == 11 || c == 21 || c == 29 || c == 37 || c == 45);
      if (pm[c] !== exp_p) chk($sformatf("das_pulse_c%0d", c), pm[c], exp_p);
    end
    n = cnt_pulses(0, 11, 50);
    chk("das_pulse_count", n, 5);
    chk("release_held_51", hm[51], 0);
    chk("release_rep_51",  rm[51], 0);

    // Press at edge 61; release coincides with the 3rd DELAY tick (edge 73).
    step_to(60);
    key_lvl = 1'b1;
    step_to(72);
    key_lvl = 1'b0;
    step_to(80);
    chk("tc_press_pulse_61", pm[61], 1);
    n = cnt_pulses(0, 62, 80);
    chk("tc_release_no_pulse", n, 0);
    chk("tc_release_held_73", hm[73], 0);
    chk("tc_release_held_72", hm[72], 1);

    // REPEAT_TICKS=0 instance: press at edge 81, hold through step 180.
    key_lvl = 1'b1;
    step_to(180);
    key_lvl = 1'b0;
    chk("hold_pulse_81", ph[81], 1);
    n = cnt_pulses(1, 81, 180);
    chk("hold_pulse_count", n, 1);
    n = 0;
    for (int unsigned c = 81; c <= 180; c++) if (hh[c] !== 1'b1 || rh[c] !== 1'b0) n++;
    chk("hold_held_norep", n, 0);

    // Key rises while enable=0, enable returns with key held: no pulse.
    step_to(190);
    enable  = 1'b0;
    key_lvl = 1'b1;
    step_to(195);
    enable  = 1'b1;
    step_to(205);
    n = cnt_pulses(0, 191, 205);
    chk("en_held_no_pulse", n, 0);
    chk("en_held_idle_205", hm[205], 0);
    key_lvl = 1'b0;
    step_to(210);
    key_lvl = 1'b1;
    step_to(215);
    key_lvl = 1'b0;
    chk("repress_pulse_211", pm[211], 1);
    n = cnt_pulses(0, 206, 215);
    chk("repress_pulse_count", n, 1);

    // REPEAT_TICKS=1, tick_en held high: pulses at 223, 226, then every other cycle.
    step_to(220);
    tick_all = 1'b1;
    tick_en  = 1'b1;
    step_to(222);
    key_lvl = 1'b1;
    step_to(260);
    n = 0;
    for (int unsigned c = 223; c < 260; c++) if (pf[c] === 1'b1 && pf[c+1] === 1'b1) n++;
    chk("fast_no_adjacent", n, 0);
    n = cnt_pulses(2, 223, 260);
    chk("fast_pulse_count", n, 19);
    chk("fast_pulse_228", pf[228], 1);
    chk("main_repeating_260", rm[260], 1);

    // Reset mid-REPEAT: outputs drop without waiting for a clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_main", {29'd0, m_pulse, m_held, m_rep}, 0);
    chk("async_rst_fast", {29'd0, f_pulse, f_held, f_rep}, 0);
    @(negedge clk);
    tick_all = 1'b0;
    rst_n    = 1'b1;
    step_to(266);
    chk("post_rst_pulse_261", pm[261], 1);
    n = cnt_pulses(0, 261, 266);
    chk("post_rst_pulse_count", n, 1);
    key_lvl = 1'b0;
    step_to(268);
    chk("final_idle_held", hm[268], 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_key_repeat_pulser
